// File: rtl/enc_8x3_pend_if.sv
// Event-encoder bus: raw event lines in, one binary index out per valid/ready transfer,
// plus pending-count and drop-pulse status.
interface enc_8x3_pend_if;
  logic [7:0] in;
  logic [2:0] out;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] pend_cnt;
  logic       dropped;

  modport master (
    input  in, out_ready,
    output out, out_valid, pend_cnt, dropped
  );

  modport slave (
    output in, out_ready,
    input  out, out_valid, pend_cnt, dropped
  );
endinterface

// File: rtl/enc_8x3_pend.sv
// Sticky 8-line event capture, emitted one 3-bit index at a time over valid/ready.
// Fixed-priority (highest index) or round-robin search, selected by PRIORITY_MODE.

// One pending bit. A new event on the same cycle as its grant re-arms the bit (set beats clear).
module enc_8x3_pend_cell (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic pend,
  output logic hit
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= 1'b0;
    else     pend <= (pend & ~clr) | set;
  end

  // Merge into a bit that stays pending: the event is lost.
  assign hit = set & pend & ~clr;
endmodule

module enc_8x3_pend #(
  parameter int PRIORITY_MODE = 0
) (
  input  logic             clk,
  input  logic             rst,
  enc_8x3_pend_if.master   bus
);
  localparam int NUM_LINES = 8;

  logic [NUM_LINES-1:0] req;
  logic [NUM_LINES-1:0] pend;
  logic [NUM_LINES-1:0] hit;
  logic [NUM_LINES-1:0] clr_mask;
  logic [NUM_LINES-1:0] pend_next;
  logic [2:0]           sel;
  logic [2:0]           idx;
  logic [3:0]           cnt_next;
  logic                 load;

  logic [2:0] out_q;
  logic       vld_q;
  logic [2:0] last_q;
  logic [3:0] cnt_q;
  logic       drop_q;

  assign req = bus.in;

  enc_8x3_pend_cell u_cell [NUM_LINES-1:0] (
    .clk  (clk),
    .rst  (rst),
    .set  (req),
    .clr  (clr_mask),
    .pend (pend),
    .hit  (hit)
  );

  // A new code is taken whenever something is pending and the output slot is free or draining.
  assign load = (|pend) && (!vld_q || bus.out_ready);

  always_comb begin
    sel = '0;
    idx = '0;
    if (PRIORITY_MODE == 0) begin
      for (int k = 0; k < NUM_LINES; k++)
        if (pend[k]) sel = 3'(k);
    end else begin
      // Descending offsets so the nearest index after last_q wins; offset 8 wraps to last_q itself.
      for (int i = NUM_LINES; i >= 1; i--) begin
        idx = last_q + 3'(i);
        if (pend[idx]) sel = idx;
      end
    end
  end

  always_comb begin
    clr_mask = '0;
    if (load) clr_mask[sel] = 1'b1;
  end

  assign pend_next = (pend & ~clr_mask) | req;

  always_comb begin
    cnt_next = '0;
    for (int k = 0; k < NUM_LINES; k++)
      cnt_next = cnt_next + {3'b000, pend_next[k]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= 3'd0;
      vld_q  <= 1'b0;
      last_q <= 3'd7;
      cnt_q  <= 4'd0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= |hit;
      cnt_q  <= cnt_next;
      if (load) begin
        out_q  <= sel;
        vld_q  <= 1'b1;
        last_q <= sel;
      end else if (vld_q && bus.out_ready) begin
        vld_q  <= 1'b0;
      end
    end
  end

  assign bus.out       = out_q;
  assign bus.out_valid = vld_q;
  assign bus.pend_cnt  = cnt_q;
  assign bus.dropped   = drop_q;
endmodule

// File: tb/tb_enc_8x3_pend.sv
// Directed bench for both search modes side by side, checked against a set-based model
// on every falling edge plus literal expectations on the model at key points.
module tb_enc_8x3_pend;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ev;
  logic       rdy;

  int n_cmp = 0;
  int n_bad = 0;

  enc_8x3_pend_if bus0 ();
  enc_8x3_pend_if bus1 ();

  assign bus0.in = ev;
  assign bus0.out_ready = rdy;
  assign bus1.in = ev;
  assign bus1.out_ready = rdy;

  enc_8x3_pend #(.PRIORITY_MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  enc_8x3_pend #(.PRIORITY_MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  // Model: pending set as a byte, code register, valid flag, pointer, status.
  logic [7:0] m_p [2];
  int m_out [2];
  int m_vld [2];
  int m_last [2];
  int m_cnt [2];
  int m_drop [2];

  function automatic int pick(input int mode, input logic [7:0] p, input int last);
    if (mode == 0) begin
      for (int k = 7; k >= 0; k--) if (p[k]) return k;
    end else begin
      for (int s = 1; s <= 8; s++) if (p[(last + s) % 8]) return (last + s) % 8;
    end
    return -1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      for (int m = 0; m < 2; m++) begin
        if (rst) begin
          m_p[m] = 8'h00; m_out[m] = 0; m_vld[m] = 0;
          m_last[m] = 7; m_cnt[m] = 0; m_drop[m] = 0;
        end else begin
          int s;
          logic [7:0] taken;
          s = -1;
          taken = 8'h00;
          if (m_p[m] != 8'h00 && (m_vld[m] == 0 || rdy)) s = pick(m, m_p[m], m_last[m]);
          if (s >= 0) taken[s] = 1'b1;
          m_drop[m] = ((ev & m_p[m] & ~taken) != 8'h00) ? 1 : 0;
          m_p[m] = (m_p[m] & ~taken) | ev;
          m_cnt[m] = $countones(m_p[m]);
          if (s >= 0) begin
            m_out[m] = s; m_vld[m] = 1; m_last[m] = s;
          end else if (m_vld[m] == 1 && rdy) begin
            m_vld[m] = 0;
          end
        end
      end
    end
  end

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        cmp("m0_out",   int'(bus0.out),       m_out[0]);
        cmp("m0_valid", int'(bus0.out_valid), m_vld[0]);
        cmp("m0_cnt",   int'(bus0.pend_cnt),  m_cnt[0]);
        cmp("m0_drop",  int'(bus0.dropped),   m_drop[0]);
        cmp("m1_out",   int'(bus1.out),       m_out[1]);
        cmp("m1_valid", int'(bus1.out_valid), m_vld[1]);
        cmp("m1_cnt",   int'(bus1.pend_cnt),  m_cnt[1]);
        cmp("m1_drop",  int'(bus1.dropped),   m_drop[1]);
      end
    end
  end

  task automatic step(input logic [7:0] e, input logic r);
    ev = e;
    rdy = r;
    @(posedge clk);
    #1;
  endtask

  // Literal expectation on the model state of one mode.
  task automatic lit(input string tag, input int m, input int v, input int o, input int c);
    cmp({tag, "_valid"}, m_vld[m], v);
    if (v == 1) cmp({tag, "_out"}, m_out[m], o);
    cmp({tag, "_cnt"}, m_cnt[m], c);
  endtask

  task automatic dut_cleared(input string tag);
    cmp({tag, "_d0_out"},   int'(bus0.out),       0);
    cmp({tag, "_d0_valid"}, int'(bus0.out_valid), 0);
    cmp({tag, "_d0_cnt"},   int'(bus0.pend_cnt),  0);
    cmp({tag, "_d0_drop"},  int'(bus0.dropped),   0);
    cmp({tag, "_d1_valid"}, int'(bus1.out_valid), 0);
    cmp({tag, "_d1_cnt"},   int'(bus1.pend_cnt),  0);
  endtask

  initial begin
    rst = 1'b1;
    ev  = 8'hFF;
    rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    dut_cleared("reset");
    rst = 1'b0;
    step(8'h00, 1'b1);
    step(8'h00, 1'b1);
    lit("idle", 0, 0, 0, 0);
    cmp("idle_d0_valid", int'(bus0.out_valid), 0);

    // Single event on line 5.
    step(8'h20, 1'b1); lit("single_a", 0, 0, 0, 1);
    step(8'h00, 1'b1); lit("single_b", 0, 1, 5, 0); lit("single_b1", 1, 1, 5, 0);
    step(8'h00, 1'b1); lit("single_c", 0, 0, 0, 0);

    // Fixed priority under backpressure: 7 held, then 7,2,0.
    step(8'h85, 1'b0); lit("bp_cap", 0, 0, 0, 3);
    for (int i = 0; i < 3; i++) begin
      step(8'h00, 1'b0); lit("bp_hold", 0, 1, 7, 2);
    end
    step(8'h00, 1'b1); lit("bp_2", 0, 1, 2, 1);
    step(8'h00, 1'b1); lit("bp_0", 0, 1, 0, 0);
    step(8'h00, 1'b1); lit("bp_end", 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(8'h00, 1'b1);

    // Round-robin from a fresh pointer; line 3 re-pulsed after grant 5 wraps in after 7.
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    step(8'hFF, 1'b1); lit("rr_load", 1, 0, 0, 8);
    for (int k = 0; k <= 5; k++) begin
      step(8'h00, 1'b1); lit("rr_seq", 1, 1, k, 7 - k);
    end
    step(8'h08, 1'b1); lit("rr_6", 1, 1, 6, 2);
    step(8'h00, 1'b1); lit("rr_7", 1, 1, 7, 1);
    step(8'h00, 1'b1); lit("rr_wrap3", 1, 1, 3, 0);
    step(8'h00, 1'b1); lit("rr_end", 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(8'h00, 1'b1);
    lit("drained0", 0, 0, 0, 0);

    // Collision on a pending bit, then set-beats-clear on the granted bit.
    step(8'h90, 1'b0); lit("col_cap", 0, 0, 0, 2);
    step(8'h00, 1'b0); lit("col_7", 0, 1, 7, 1);
    step(8'h10, 1'b0); lit("col_dup", 0, 1, 7, 1); cmp("col_drop", m_drop[0], 1);
    step(8'h00, 1'b0); cmp("col_drop_clr", m_drop[0], 0); lit("col_hold", 0, 1, 7, 1);
    step(8'h10, 1'b1); lit("sbc_4", 0, 1, 4, 1); cmp("sbc_nodrop", m_drop[0], 0);
    step(8'h00, 1'b1); lit("sbc_re4", 0, 1, 4, 0);
    step(8'h00, 1'b1); lit("sbc_end", 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(8'h00, 1'b1);

    // Reset asserted between edges while code 6 is presented with lines 1,0 pending.
    step(8'h43, 1'b0); lit("mid_cap", 0, 0, 0, 3);
    step(8'h00, 1'b0); lit("mid_6", 0, 1, 6, 2);
    #2 rst = 1'b1;
    #1 dut_cleared("mid_rst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(8'h00, 1'b1);
      cmp("after_rst_valid", int'(bus0.out_valid), 0);
      lit("after_rst", 0, 0, 0, 0);
    end

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/enc_8x3_pend.md
Name: enc_8x3_pend

Overview:
Sequential 8-to-3 encoder, the inverse of the team's 3-to-8 one-hot decoder: line k maps to code k. Event pulses on 8 request lines are captured into a sticky pending register. Pending events are then emitted one at a time as 3-bit codes over a valid/ready handshake. It sits between event sources (interrupt or status lines) and a consumer that accepts one binary index per transfer.

Parameters:
PRIORITY_MODE, 0, selects the search order: 0 = fixed priority, highest index wins; 1 = round-robin, ascending search starting after the last granted index.

Ports:
clk  input  1  single clock for the whole block; rising edge.
rst  input  1  asynchronous, active-high reset.
in  input  8  event pulses; bit k high in a cycle raises event k.
out  output  3  encoded index of the event being presented.
out_valid  output  1  out holds a valid code.
out_ready  input  1  consumer accepts the code this cycle.
pend_cnt  output  4  popcount of the pending register (0..8); excludes the code held in out.
dropped  output  1  one-cycle registered pulse: an event merged into a bit that was already pending.

Behaviour:
- Reset (async, rst=1), all registers cleared immediately:
  - P=0, out=3'b000, out_valid=0, pend_cnt=0, dropped=0.
  - Round-robin pointer last=3'd7, so the first search starts at index 0.
- Pending register P[7:0] is updated every clk edge as P_next = (P & ~clr_mask) | in.
  - clr_mask is the one-hot of the index loaded this cycle, or 0 if no load.
  - Set beats clear: if in[k]=1 in the same cycle bit k is loaded, P[k] stays 1 (re-armed).
- Load condition: load = (P != 0) && (!out_valid || out_ready).
  - On load: out <= selected index, out_valid <= 1, P[sel] cleared (subject to set-beats-clear).
  - Accept without load (out_valid && out_ready && P==0): out_valid <= 0; out keeps its last value.
  - While out_valid=1 and out_ready=0: out and out_valid hold stable (no change to the code).
  - Back-to-back: with out_ready held high and P nonzero, one code is emitted per cycle with no bubble.
- Selection uses the registered P only, never the raw in.
  - Latency: in pulse at edge t -> P set at t -> out_valid no earlier than edge t+1.
  - Mode 0: sel = highest set index of P.
  - Mode 1: sel = first set index scanning last+1, last+2, ... mod 8. On load, last <= sel.
  - The pointer wraps 7 -> 0.
- dropped: registered next cycle. It is high iff there exists k with in[k]=1 and P[k]=1 and k is not being cleared this cycle.
  - An event on the bit held in out (already removed from P) is not a drop; it re-pends.
- pend_cnt: registered popcount of P_next, so it always equals popcount(P). Maximum value is 8 (4'b1000).
- All outputs are registered. There is no combinational path from in or out_ready to any output.
- Reset asserted mid-transfer: the pending event and the presented code are discarded, and no handshake completes.

Test Plan:
- Reset: rst=1 with in=8'hFF -> out=0, out_valid=0, pend_cnt=0, dropped=0; after release with in=0, out_valid stays 0.
- Single event: in=8'b0010_0000 for one cycle, out_ready=1 -> next edge pend_cnt=1; following edge out=3'd5, out_valid=1, pend_cnt=0; next cycle out_valid=0.
- Fixed priority with backpressure: mode 0, in=8'b1000_0101 for one cycle, out_ready=0 -> out=7 held stable for 3 cycles with pend_cnt=2; then out_ready=1 -> codes 7, 2, 0 on consecutive cycles, then out_valid=0.
- Round-robin: mode 1, P=8'hFF loaded in one cycle, out_ready=1 -> codes 0,1,...,7 in order; pend_cnt decrements 8..0; a re-pulse of in[3] after grant 5 -> emitted after 7 as code 3 (wrap).
- Collisions and set-beats-clear:
  - in[4] pulsed twice while P[4]=1 -> dropped=1 for one cycle, pend_cnt unchanged.
  - in[4] pulsed on the exact cycle bit 4 is loaded -> out=4, P[4] remains 1, dropped=0, and 4 is re-emitted later.
- Async reset mid-transfer: out_valid=1, out=6, P=8'b0000_0011; assert rst between edges -> outputs clear before the next clk edge; after release nothing is emitted.
